// File: rtl/fetch_entry_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_entry_queue_pkg
// Description : Shared types for the fetch-entry queue: the fetch-entry
//               struct handed to decode, the realigner output bundle and
//               the compressed-halfword test.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_entry_queue_pkg;

    localparam int unsigned VLEN = 32;
    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        NoCF   = 3'd0,
        Branch = 3'd1,
        Jump   = 3'd2,
        JumpR  = 3'd3,
        Return = 3'd4
    } cf_t;

    typedef struct packed {
        cf_t             cf;
        logic [VLEN-1:0] predict_address;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [VLEN-1:0]    address;
        logic [31:0]        instruction;
        branchpredict_sbe_t branch_predict;
        exception_t         ex;
    } fetch_entry_t;

    // Up to two realigned instructions per fetch word, compacted so that
    // slot 1 is only valid when slot 0 is. The exception fields belong to
    // slot 0; a faulting word never produces a second entry.
    typedef struct packed {
        logic [1:0]            valid;
        logic [1:0][VLEN-1:0]  addr;
        logic [1:0][31:0]      instr;
        logic                  ex_valid;
        logic [XLEN-1:0]       ex_cause;
        logic [VLEN-1:0]       ex_tval;
    } fetch_realign_out_t;

    // Takes the two low opcode bits of a halfword; 2'b11 marks a 32-bit
    // instruction, anything else is a compressed one.
    function automatic logic is_compressed(input logic [1:0] h);
        return h != 2'b11;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_entry_queue_realigner.sv
`default_nettype none
// ============================================================================
// Module      : fetch_realigner
// Description : Splits each accepted 32-bit fetch word into 16/32-bit
//               instructions, stitching 32-bit instructions that straddle
//               two words. Holds the pending upper halfword and the
//               post-fault drop mode.
// Ports       : clk_i, rst_ni       - clock, async active-low reset
//               flush_i             - clears pending half and drop mode
//               accept_i            - a fetch word transfers this cycle
//               addr_i/data_i       - fetch word address and data
//               ex_valid_i/ex_cause_i - fetch fault on this word
//               realign_o           - up to two entries for this word
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_realigner
    import fetch_entry_queue_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                accept_i,
    input  logic [VLEN-1:0]     addr_i,
    input  logic [31:0]         data_i,
    input  logic                ex_valid_i,
    input  logic [XLEN-1:0]     ex_cause_i,
    output fetch_realign_out_t  realign_o
);

    logic            pend_valid_q, pend_valid_d;
    logic [VLEN-1:0] pend_addr_q,  pend_addr_d;
    logic [15:0]     pend_half_q,  pend_half_d;
    logic            drop_q,       drop_d;

    logic            w_contig;
    logic            w_slot;
    logic [VLEN-1:0] w_lo_addr;
    logic [VLEN-1:0] w_hi_addr;

    assign w_lo_addr = {addr_i[VLEN-1:2], 2'b00};
    assign w_hi_addr = {addr_i[VLEN-1:2], 2'b10};
    // The pending half is always an upper halfword, so the word that
    // completes it is the next aligned word.
    assign w_contig  = pend_valid_q && !addr_i[1] &&
                       (addr_i == pend_addr_q + {{(VLEN-2){1'b0}}, 2'b10});

    always_comb begin
        realign_o    = '0;
        w_slot       = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_half_d  = pend_half_q;
        drop_d       = drop_q;

        if (flush_i) begin
            pend_valid_d = 1'b0;
            drop_d       = 1'b0;
        end else if (accept_i && !drop_q) begin
            // A discontiguous pending half is silently discarded here.
            pend_valid_d = 1'b0;
            if (ex_valid_i) begin
                realign_o.valid[0] = 1'b1;
                realign_o.addr[0]  = w_contig ? pend_addr_q : addr_i;
                realign_o.ex_valid = 1'b1;
                realign_o.ex_cause = ex_cause_i;
                realign_o.ex_tval  = addr_i;
                drop_d             = 1'b1;
            end else begin
                if (w_contig) begin
                    realign_o.valid[w_slot] = 1'b1;
                    realign_o.addr[w_slot]  = pend_addr_q;
                    realign_o.instr[w_slot] = {data_i[15:0], pend_half_q};
                    w_slot                  = 1'b1;
                end
                if (!w_contig && !addr_i[1]) begin
                    realign_o.valid[w_slot] = 1'b1;
                    realign_o.addr[w_slot]  = w_lo_addr;
                    realign_o.instr[w_slot] = is_compressed(data_i[1:0]) ?
                                              {16'h0000, data_i[15:0]} : data_i;
                    w_slot                  = 1'b1;
                end
                // Upper halfword starts an instruction unless the lower
                // halfword began a full 32-bit one.
                if (w_contig || addr_i[1] || is_compressed(data_i[1:0])) begin
                    if (is_compressed(data_i[17:16])) begin
                        realign_o.valid[w_slot] = 1'b1;
                        realign_o.addr[w_slot]  = w_hi_addr;
                        realign_o.instr[w_slot] = {16'h0000, data_i[31:16]};
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = w_hi_addr;
                        pend_half_d  = data_i[31:16];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_half_q  <= '0;
            drop_q       <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_half_q  <= pend_half_d;
            drop_q       <= drop_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_entry_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_entry_queue
// Description : Producer side of the fetch-to-decode handshake. Realigns
//               32-bit fetch words into instructions and buffers them in a
//               circular FIFO whose head register drives decode directly.
// Ports       : clk_i, rst_ni        - clock, async active-low reset
//               flush_i              - clears all state
//               fetch_valid_i/fetch_ready_o - fetch word handshake
//               fetch_addr_i/fetch_data_i   - fetch word address/data
//               fetch_ex_valid_i/fetch_ex_cause_i - fetch fault
//               fetch_entry_o/fetch_entry_valid_o/fetch_entry_ready_i
//                                    - decode handshake
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_entry_queue
    import fetch_entry_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4    // power of two, >= 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             fetch_valid_i,
    output logic             fetch_ready_o,
    input  logic [VLEN-1:0]  fetch_addr_i,
    input  logic [31:0]      fetch_data_i,
    input  logic             fetch_ex_valid_i,
    input  logic [XLEN-1:0]  fetch_ex_cause_i,
    output fetch_entry_t     fetch_entry_o,
    output logic             fetch_entry_valid_o,
    input  logic             fetch_entry_ready_i
);

    localparam int unsigned C_PTR_W = $clog2(DEPTH);
    localparam int unsigned C_CNT_W = C_PTR_W + 1;
    // A word can yield two entries, so accept only with two free slots.
    localparam logic [C_CNT_W-1:0] C_READY_MAX = C_CNT_W'(DEPTH - 2);

    fetch_entry_t         mem_q [DEPTH];
    logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [C_CNT_W-1:0]   count_q,  count_d;

    logic                 w_accept;
    logic                 w_pop;
    logic [C_CNT_W-1:0]   w_push_cnt;
    logic [C_PTR_W-1:0]   w_wr_ptr_nxt;
    fetch_realign_out_t   w_realign;
    fetch_entry_t         w_entry [2];

    assign fetch_ready_o       = (count_q <= C_READY_MAX) && !flush_i;
    assign fetch_entry_valid_o = (count_q != '0);
    assign fetch_entry_o       = mem_q[rd_ptr_q];

    assign w_accept = fetch_valid_i && fetch_ready_o;
    assign w_pop    = fetch_entry_valid_o && fetch_entry_ready_i;

    fetch_realigner u_realigner (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .accept_i   (w_accept),
        .addr_i     (fetch_addr_i),
        .data_i     (fetch_data_i),
        .ex_valid_i (fetch_ex_valid_i),
        .ex_cause_i (fetch_ex_cause_i),
        .realign_o  (w_realign)
    );

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_entry[s]                   = '0;
            w_entry[s].address           = w_realign.addr[s];
            w_entry[s].instruction       = w_realign.instr[s];
            w_entry[s].branch_predict.cf = NoCF;
        end
        w_entry[0].ex.valid = w_realign.ex_valid;
        w_entry[0].ex.cause = w_realign.ex_cause;
        w_entry[0].ex.tval  = w_realign.ex_tval;
    end

    assign w_push_cnt   = C_CNT_W'(w_realign.valid[0]) + C_CNT_W'(w_realign.valid[1]);
    assign w_wr_ptr_nxt = wr_ptr_q + C_PTR_W'(1);

    always_comb begin
        count_d  = count_q + w_push_cnt - C_CNT_W'(w_pop);
        wr_ptr_d = wr_ptr_q + w_push_cnt[C_PTR_W-1:0];
        rd_ptr_d = rd_ptr_q + C_PTR_W'(w_pop);
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (!flush_i) begin
                if (w_realign.valid[0]) begin
                    mem_q[wr_ptr_q] <= w_entry[0];
                end
                if (w_realign.valid[1]) begin
                    mem_q[w_wr_ptr_nxt] <= w_entry[1];
                end
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_entry_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_entry_queue
// Description : Self-checking bench for fetch_entry_queue. A halfword-stream
//               reference model predicts the entry sequence and the
//               handshake signals; directed scenarios plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_entry_queue;
    import fetch_entry_queue_pkg::*;

    localparam int DEPTH = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             flush_i = 1'b0;
    logic             fetch_valid_i = 1'b0;
    logic             fetch_ready_o;
    logic [VLEN-1:0]  fetch_addr_i = '0;
    logic [31:0]      fetch_data_i = '0;
    logic             fetch_ex_valid_i = 1'b0;
    logic [XLEN-1:0]  fetch_ex_cause_i = '0;
    fetch_entry_t     fetch_entry_o;
    logic             fetch_entry_valid_o;
    logic             fetch_entry_ready_i = 1'b0;

    fetch_entry_queue #(.DEPTH(DEPTH)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .fetch_valid_i       (fetch_valid_i),
        .fetch_ready_o       (fetch_ready_o),
        .fetch_addr_i        (fetch_addr_i),
        .fetch_data_i        (fetch_data_i),
        .fetch_ex_valid_i    (fetch_ex_valid_i),
        .fetch_ex_cause_i    (fetch_ex_cause_i),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_entry_ready_i (fetch_entry_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        exv;
        logic [31:0] cause;
        logic [31:0] tval;
    } exp_t;

    exp_t        mq[$];
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_addr = '0;
    logic [15:0] m_pend_h = '0;
    bit          m_drop = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] ins, input logic exv,
                            input logic [31:0] cause, input logic [31:0] tval);
        exp_t e;
        e.addr = a; e.instr = ins; e.exv = exv; e.cause = cause; e.tval = tval;
        mq.push_back(e);
    endtask

    // Reference: list the halfwords this word contributes (a contiguous
    // pending half first), then walk them as an instruction stream.
    task automatic model_word(input logic [31:0] a, input logic [31:0] d,
                              input logic exv, input logic [31:0] cause);
        logic [15:0] hw [3];
        logic [31:0] ha [3];
        int n = 0;
        int i = 0;
        bit contig;
        contig = m_pend && !a[1] && (a == m_pend_addr + 32'd2);
        if (m_drop) return;
        if (exv) begin
            push_exp(contig ? m_pend_addr : a, 32'h0, 1'b1, cause, a);
            m_pend = 1'b0;
            m_drop = 1'b1;
            return;
        end
        if (contig) begin hw[n] = m_pend_h; ha[n] = m_pend_addr; n++; end
        m_pend = 1'b0;
        if (!a[1]) begin hw[n] = d[15:0]; ha[n] = {a[31:2], 2'b00}; n++; end
        hw[n] = d[31:16]; ha[n] = {a[31:2], 2'b10}; n++;
        while (i < n) begin
            if (hw[i][1:0] != 2'b11) begin
                push_exp(ha[i], {16'h0, hw[i]}, 1'b0, 32'h0, 32'h0);
                i++;
            end else if (i + 1 < n) begin
                push_exp(ha[i], {hw[i+1], hw[i]}, 1'b0, 32'h0, 32'h0);
                i += 2;
            end else begin
                m_pend = 1'b1; m_pend_addr = ha[i]; m_pend_h = hw[i];
                i++;
            end
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_pend = 1'b0;
        m_drop = 1'b0;
    endtask

    // One clock: drive at the falling edge, check outputs against the model,
    // advance the model to match the coming rising edge.
    task automatic step(input logic fv, input logic [31:0] a, input logic [31:0] d,
                        input logic exv, input logic [31:0] cause,
                        input logic fl, input logic rdy);
        bit exp_ready;
        @(negedge clk_i);
        fetch_valid_i = fv; fetch_addr_i = a; fetch_data_i = d;
        fetch_ex_valid_i = exv; fetch_ex_cause_i = cause;
        flush_i = fl; fetch_entry_ready_i = rdy;
        #1;
        exp_ready = ((DEPTH - mq.size()) >= 2) && !fl;
        check_val("fetch_ready", fetch_ready_o, exp_ready);
        check_val("entry_valid", fetch_entry_valid_o, mq.size() != 0);
        if (mq.size() != 0) begin
            check_val("head_addr",  fetch_entry_o.address,     mq[0].addr);
            check_val("head_instr", fetch_entry_o.instruction, mq[0].instr);
            check_val("head_exv",   fetch_entry_o.ex.valid,    mq[0].exv);
            check_val("head_cf",    fetch_entry_o.branch_predict.cf, NoCF);
            if (mq[0].exv) begin
                check_val("head_cause", fetch_entry_o.ex.cause, mq[0].cause);
                check_val("head_tval",  fetch_entry_o.ex.tval,  mq[0].tval);
            end
        end
        if (fl) begin
            model_clear();
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (fv && exp_ready) model_word(a, d, exv, cause);
        end
        @(posedge clk_i);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, rdy);
    endtask

    task automatic expect_head(input string tag, input logic [31:0] a, input logic [31:0] ins);
        #1;
        check_val({tag, "_valid"}, fetch_entry_valid_o, 1'b1);
        check_val({tag, "_addr"},  fetch_entry_o.address, a);
        check_val({tag, "_instr"}, fetch_entry_o.instruction, ins);
    endtask

    initial begin
        logic [31:0] r_addr;
        logic [31:0] r_data;
        logic [31:0] r_next;
        logic        r_fv, r_exv, r_fl, r_rdy;

        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst_valid", fetch_entry_valid_o, 1'b0);
        check_val("rst_ready", fetch_ready_o, 1'b1);
        check_val("rst_entry", fetch_entry_o.address | fetch_entry_o.instruction, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Two compressed halfwords in one word.
        step(1'b1, 32'h8000_0000, 32'h4501_4505, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_head("t1a", 32'h8000_0000, 32'h0000_4505);
        idle(1'b1);
        expect_head("t1b", 32'h8000_0002, 32'h0000_4501);
        idle(1'b1);

        // 32-bit instruction straddling two words.
        step(1'b1, 32'h8000_0000, 32'h0513_4505, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_head("t2a", 32'h8000_0000, 32'h0000_4505);
        step(1'b1, 32'h8000_0004, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b1);
        expect_head("t2b", 32'h8000_0002, 32'h0000_0513);
        repeat (3) idle(1'b1);

        // Back-pressure: ready drops once fewer than two slots are free.
        step(1'b1, 32'h8000_0100, 32'h4505_4505, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h8000_0104, 32'h4501_4505, 1'b0, 32'h0, 1'b0, 1'b0);
        #1 check_val("full_ready", fetch_ready_o, 1'b0);
        step(1'b1, 32'h8000_0108, 32'h4505_4505, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (5) idle(1'b1);

        // Fault: one exception entry, then drop mode until flush.
        step(1'b1, 32'h8000_1000, 32'hdead_beef, 1'b1, 32'h1, 1'b0, 1'b0);
        #1;
        check_val("ex_valid", fetch_entry_o.ex.valid, 1'b1);
        check_val("ex_cause", fetch_entry_o.ex.cause, 32'h1);
        check_val("ex_tval",  fetch_entry_o.ex.tval,  32'h8000_1000);
        check_val("ex_instr", fetch_entry_o.instruction, 32'h0);
        step(1'b1, 32'h8000_1004, 32'h4505_4505, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h8000_1008, 32'h4505_4505, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h8000_100c, 32'h4505_4505, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with three entries and a pending half held.
        step(1'b1, 32'h8000_3000, 32'h4505_4505, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h8000_3004, 32'h0513_4505, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h8000_3008, 32'h4505_4505, 1'b0, 32'h0, 1'b1, 1'b1);
        #1 check_val("flush_valid", fetch_entry_valid_o, 1'b0);
        step(1'b1, 32'h8000_2002, 32'h4505_0000, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_head("t5", 32'h8000_2002, 32'h0000_4505);
        idle(1'b1);

        // Pop plus two pushes at count two, walking the pointers round.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h8000_5000 + 32'(k * 8), 32'h4501_4505, 1'b0, 32'h0, 1'b0, 1'b0);
            step(1'b1, 32'h8000_5004 + 32'(k * 8), 32'h4503_4507, 1'b0, 32'h0, 1'b0, 1'b1);
            repeat (3) idle(1'b1);
        end

        // Random traffic.
        r_next = 32'h8000_4000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) r_addr = 32'h8000_0000 | ($urandom & 32'h0000_fffe);
            else r_addr = r_next;
            r_data = $urandom;
            if ($urandom_range(0, 1) == 1) r_data[1:0]   = 2'b11;
            if ($urandom_range(0, 1) == 1) r_data[17:16] = 2'b11;
            r_fv  = ($urandom_range(0, 3) != 0);
            r_exv = ($urandom_range(0, 39) == 0);
            r_fl  = ($urandom_range(0, 29) == 0);
            r_rdy = ($urandom_range(0, 9) < 7);
            if (r_fv && ((DEPTH - mq.size()) >= 2) && !r_fl)
                r_next = {r_addr[31:2], 2'b00} + 32'd4;
            step(r_fv, r_addr, r_data, r_exv, $urandom_range(0, 15), r_fl, r_rdy);
        end

        // Asynchronous reset in the middle of traffic.
        step(1'b1, 32'h8000_7000, 32'h0513_4505, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk_i);
        fetch_valid_i = 1'b0; flush_i = 1'b0; fetch_entry_ready_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check_val("arst_valid", fetch_entry_valid_o, 1'b0);
        check_val("arst_ready", fetch_ready_o, 1'b1);
        model_clear();
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(1'b1, 32'h8000_7004, 32'h4501_0000, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_head("arst_after", 32'h8000_7004, 32'h0000_0000);
        repeat (3) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
